// File: rtl/tv80_membridge_if.sv
`default_nettype none
// ============================================================================
// Module   : tv80_membridge_if
// Brief    : TV80 CPU bus plus request/ack backend bundle for tv80_membridge.
// Revision : 1.0
// ============================================================================
interface tv80_membridge_if;
    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic        m1_n;
    logic [15:0] A;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_di;
    logic        wait_n;
    logic        bk_req;
    logic [15:0] bk_addr;
    logic [7:0]  bk_wdata;
    logic        bk_we;
    logic        bk_io;
    logic        bk_ack;
    logic [7:0]  bk_rdata;
    logic [7:0]  int_vec;
    logic        err;

    // Bridge view
    modport slave (
        input  mreq_n, iorq_n, rd_n, wr_n, m1_n, A, cpu_dout,
        input  bk_ack, bk_rdata, int_vec,
        output cpu_di, wait_n, bk_req, bk_addr, bk_wdata, bk_we, bk_io, err
    );

    // CPU + backend environment view
    modport master (
        output mreq_n, iorq_n, rd_n, wr_n, m1_n, A, cpu_dout,
        output bk_ack, bk_rdata, int_vec,
        input  cpu_di, wait_n, bk_req, bk_addr, bk_wdata, bk_we, bk_io, err
    );
endinterface
`default_nettype wire

// File: rtl/tv80_membridge.sv
`default_nettype none
// ============================================================================
// Module   : tv80_membridge
// Brief    : Turns TV80 memory/IO cycles into level requests on a backend,
//            holding the CPU in wait states until ack, minimum wait or timeout.
// Revision : 1.0
// ============================================================================
module tv80_membridge #(
    parameter int MIN_WAIT = 0,
    parameter int TIMEOUT  = 255
) (
    input logic             clk,
    input logic             reset,
    tv80_membridge_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        STRETCH = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [7:0] c_CNT_MAX    = 8'hFF;
    localparam logic [7:0] c_ABORT_DATA = 8'hFF;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
    logic        r_bk_req, w_bk_req_nxt;
    logic [15:0] r_bk_addr, w_bk_addr_nxt;
    logic [7:0]  r_bk_wdata, w_bk_wdata_nxt;
    logic        r_bk_we, w_bk_we_nxt;
    logic        r_bk_io, w_bk_io_nxt;
    logic [7:0]  r_cpu_di, w_cpu_di_nxt;
    logic        r_err, w_err_nxt;
    logic        w_intack, w_access, w_min_met, w_timeout;

    // Decisions use the post-increment count so "reaches N" means this edge.
    always_comb begin
        w_intack  = !bus.m1_n && !bus.iorq_n;
        w_access  = (!bus.mreq_n || !bus.iorq_n) && (!bus.rd_n || !bus.wr_n) && !w_intack;
        w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 8'd1;
        w_min_met = int'(w_cnt_inc) >= MIN_WAIT;
        w_timeout = int'(w_cnt_inc) == TIMEOUT;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_bk_req_nxt   = r_bk_req;
        w_bk_addr_nxt  = r_bk_addr;
        w_bk_wdata_nxt = r_bk_wdata;
        w_bk_we_nxt    = r_bk_we;
        w_bk_io_nxt    = r_bk_io;
        w_cpu_di_nxt   = r_cpu_di;
        w_err_nxt      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    w_bk_addr_nxt  = bus.A;
                    w_bk_wdata_nxt = bus.cpu_dout;
                    w_bk_we_nxt    = !bus.wr_n;
                    w_bk_io_nxt    = !bus.iorq_n;
                    w_bk_req_nxt   = 1'b1;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = REQ;
                end else if (w_intack) begin
                    w_cpu_di_nxt = bus.int_vec;
                    w_state_nxt  = DONE;
                end
            end
            REQ: begin
                w_cnt_nxt = w_cnt_inc;
                // An ack landing on the timeout cycle still counts as success.
                if (bus.bk_ack) begin
                    w_bk_req_nxt = 1'b0;
                    if (!r_bk_we) w_cpu_di_nxt = bus.bk_rdata;
                    w_state_nxt = w_min_met ? DONE : STRETCH;
                end else if (w_timeout) begin
                    w_bk_req_nxt = 1'b0;
                    w_cpu_di_nxt = c_ABORT_DATA;
                    w_err_nxt    = 1'b1;
                    w_state_nxt  = DONE;
                end
            end
            STRETCH: begin
                w_cnt_nxt = w_cnt_inc;
                if (w_min_met) w_state_nxt = DONE;
            end
            DONE: begin
                if (bus.mreq_n && bus.iorq_n) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bk_req   <= 1'b0;
            r_bk_addr  <= '0;
            r_bk_wdata <= '0;
            r_bk_we    <= 1'b0;
            r_bk_io    <= 1'b0;
            r_cpu_di   <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bk_req   <= w_bk_req_nxt;
            r_bk_addr  <= w_bk_addr_nxt;
            r_bk_wdata <= w_bk_wdata_nxt;
            r_bk_we    <= w_bk_we_nxt;
            r_bk_io    <= w_bk_io_nxt;
            r_cpu_di   <= w_cpu_di_nxt;
            r_err      <= w_err_nxt;
        end
    end

    // Combinational so the CPU is stalled in the very first strobe-low cycle.
    assign bus.wait_n   = reset || !((w_access || w_intack) && (r_state != DONE));
    assign bus.bk_req   = r_bk_req;
    assign bus.bk_addr  = r_bk_addr;
    assign bus.bk_wdata = r_bk_wdata;
    assign bus.bk_we    = r_bk_we;
    assign bus.bk_io    = r_bk_io;
    assign bus.cpu_di   = r_cpu_di;
    assign bus.err      = r_err;
endmodule
`default_nettype wire
